fifo_wr_arbiter: RTL and testbench

Write-side controller for the 8-deep asynchronous FIFO. It shares the single FIFO write port between NREQ requesters using round-robin arbitration with bounded bursts. It owns the write pointer, Gray-encodes it for the read domain, and generates the full flag from a 2-flop synchronised copy of the read-domain Gray pointer. It sits entirely in the wclk domain and drives the memory write port: wr_en, wr_addr and wr_data.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_wr_arbiter_if.sv | 39 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO controllers: default geometry,
// FSM state encoding and Gray/binary pointer conversion helpers.
package fifo_pkg;

  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_PTR_SIZE   = $clog2(FIFO_DEPTH);
  localparam int FIFO_DATA_WIDTH = 8;

  // Conversions work on a wide word; callers zero-extend and truncate.
  localparam int GRAY_MAX_W = 16;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester, memory write-port and pointer-exchange signals of the FIFO write side.
// Optional wr_level output is present when FIFO_WR_ARB_LEVEL_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
  parameter int PTR_SIZE   = fifo_pkg::FIFO_PTR_SIZE
);

  logic [NREQ-1:0]            req;
  logic [NREQ*DATA_WIDTH-1:0] din;
  logic [NREQ-1:0]            ack;
  logic [NREQ-1:0]            gnt;
  logic [PTR_SIZE:0]          rptr_gray;
  logic [PTR_SIZE:0]          wptr_gray;
  logic                       wr_en;
  logic [PTR_SIZE-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       fifo_full;
`ifdef FIFO_WR_ARB_LEVEL_EN
  logic [PTR_SIZE:0]          wr_level;
`endif

  modport master (
    input  req, din, rptr_gray,
    output ack, gnt, wptr_gray, wr_en, wr_addr, wr_data, fifo_full
`ifdef FIFO_WR_ARB_LEVEL_EN
    , output wr_level
`endif
  );

  modport slave (
    output req, din, rptr_gray,
    input  ack, gnt, wptr_gray, wr_en, wr_addr, wr_data, fifo_full
`ifdef FIFO_WR_ARB_LEVEL_EN
    , input wr_level
`endif
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin first-one search: the lowest set request at or above ptr_i,
// wrapping around, returned one-hot together with a valid flag.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic            valid_o
);

  int idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: round-robin burst arbitration of the
// write port, Gray write pointer and full flag. Optional: FIFO_WR_ARB_LEVEL_EN.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PTR_SIZE   = FIFO_PTR_SIZE,
  parameter int BURST_LEN  = 4
) (
  input logic              wclk,
  input logic              reset,
  fifo_wr_arbiter_if.master bus
);

  localparam int PW = $clog2(NREQ);
  localparam int AW = PTR_SIZE + 1;
  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_e                state_q;
  logic [NREQ-1:0]       gnt_q;
  logic [PW-1:0]         owner_q;
  logic [PW-1:0]         rr_ptr_q;
  logic [3:0]            burst_cnt_q;
  logic [AW-1:0]         wbin_q;
  logic [AW-1:0]         wbin_d;
  logic [AW-1:0]         wptr_gray_q;
  logic [AW-1:0]         rq1_q;
  logic [AW-1:0]         rq2_q;
  logic                  wr_en_q;
  logic [PTR_SIZE-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [NREQ-1:0]       pick_oh;
  logic                  pick_valid;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         next_rr;
  logic                  owner_req;
  logic                  full;
  logic                  accept;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick_oh),
    .valid_o (pick_valid)
  );

  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_idx = PW'(i);
    end
    next_rr   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
    owner_req = bus.req[owner_q];
    full      = (wptr_gray_q == {~rq2_q[PTR_SIZE:PTR_SIZE-1], rq2_q[PTR_SIZE-2:0]});
    accept    = (state_q == ST_BURST) && owner_req && !full;
    wbin_d    = wbin_q + AW'(1);
  end

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wbin_q      <= '0;
      wptr_gray_q <= '0;
      rq1_q       <= '0;
      rq2_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      rq1_q   <= bus.rptr_gray;
      rq2_q   <= rq1_q;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid && !full) begin
            gnt_q       <= pick_oh;
            owner_q     <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= ST_BURST;
          end
        end
        ST_BURST: begin
          // A dropped request ends the burst even while the FIFO is full.
          if (!owner_req) begin
            gnt_q    <= '0;
            rr_ptr_q <= next_rr;
            state_q  <= ST_IDLE;
          end else if (accept) begin
            wr_en_q     <= 1'b1;
            wr_addr_q   <= wbin_q[PTR_SIZE-1:0];
            wr_data_q   <= bus.din[owner_q*DATA_WIDTH +: DATA_WIDTH];
            wbin_q      <= wbin_d;
            wptr_gray_q <= AW'(bin2gray(GRAY_MAX_W'(wbin_d)));
            burst_cnt_q <= burst_cnt_q + 4'd1;
            if (burst_cnt_q + 4'd1 == BURST_MAX) begin
              gnt_q    <= '0;
              rr_ptr_q <= next_rr;
              state_q  <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack       = accept ? gnt_q : '0;
  assign bus.gnt       = gnt_q;
  assign bus.wptr_gray = wptr_gray_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.fifo_full = full;

`ifdef FIFO_WR_ARB_LEVEL_EN
  logic [AW-1:0] wr_level_q;

  // The read pointer is seen late, so this level can only over-report.
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      wr_level_q <= '0;
    end else begin
      wr_level_q <= wbin_q - AW'(gray2bin(GRAY_MAX_W'(rq2_q)));
    end
  end

  assign bus.wr_level = wr_level_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector tables for single-requester and
// full/release behaviour, plus loops for rotation, pointer wrap and reset mid-burst.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int PS   = 3;

  logic wclk = 1'b0;
  logic reset;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .PTR_SIZE(PS)) bus ();

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DATA_WIDTH(DW), .PTR_SIZE(PS), .BURST_LEN(4)
  ) dut (
    .wclk  (wclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] dval;
    logic [3:0] rptr;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       wrEn;
    logic [2:0] addr;
    logic [7:0] data;
    logic [3:0] wptr;
    logic       full;
  } vec_t;

  vec_t vecs[$];

  int testsRun    = 0;
  int testsFailed = 0;

  int         cyc;
  logic [3:0] hist[0:255];
  logic       expWrEn;
  logic [2:0] expAddr;
  logic [7:0] expData;
  logic [3:0] expWbin;

  function automatic logic [3:0] tbGray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic [3:0] req, input logic [7:0] dval,
                              input logic [3:0] rptr, input logic [3:0] gnt,
                              input logic [3:0] ack, input logic wrEn,
                              input logic [2:0] addr, input logic [7:0] data,
                              input logic [3:0] wptr, input logic full);
    vec_t v;
    v.req = req; v.dval = dval; v.rptr = rptr; v.gnt = gnt; v.ack = ack;
    v.wrEn = wrEn; v.addr = addr; v.data = data; v.wptr = wptr; v.full = full;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [31:0] din, input logic [3:0] rptr);
    bus.req       = req;
    bus.din       = din;
    bus.rptr_gray = rptr;
    #1;
  endtask

  task automatic resetExp();
    cyc     = 0;
    expWrEn = 1'b0;
    expAddr = '0;
    expData = '0;
    expWbin = '0;
  endtask

  task automatic doReset();
    reset         = 1'b1;
    bus.req       = '0;
    bus.din       = '0;
    bus.rptr_gray = '0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    reset = 1'b0;
    #1;
    resetExp();
  endtask

  task automatic runVectors(input string tag);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, {4{vecs[i].dval}}, vecs[i].rptr);
      checkOutput($sformatf("%s[%0d].gnt", tag, i), 32'(bus.gnt), 32'(vecs[i].gnt));
      checkOutput($sformatf("%s[%0d].ack", tag, i), 32'(bus.ack), 32'(vecs[i].ack));
      checkOutput($sformatf("%s[%0d].wr_en", tag, i), 32'(bus.wr_en), 32'(vecs[i].wrEn));
      checkOutput($sformatf("%s[%0d].wr_addr", tag, i), 32'(bus.wr_addr), 32'(vecs[i].addr));
      checkOutput($sformatf("%s[%0d].wr_data", tag, i), 32'(bus.wr_data), 32'(vecs[i].data));
      checkOutput($sformatf("%s[%0d].wptr_gray", tag, i), 32'(bus.wptr_gray), 32'(vecs[i].wptr));
      checkOutput($sformatf("%s[%0d].fifo_full", tag, i), 32'(bus.fifo_full), 32'(vecs[i].full));
      tick();
    end
    vecs.delete();
  endtask

  // One cycle with a read side lagging the bench's write count by four cycles.
  task automatic cycleStep(input string tag, input logic [3:0] mask,
                           input logic [3:0] expGnt, input logic [3:0] expAck);
    logic [31:0] dinv;
    logic [3:0]  rptr;
    int          o;
    for (int i = 0; i < NREQ; i++) dinv[i*8 +: 8] = {4'(i), 4'(cyc)};
    rptr = (cyc >= 4) ? tbGray(hist[cyc-4]) : 4'h0;
    hist[cyc] = expWbin;
    applyStimulus(mask, dinv, rptr);
    checkOutput($sformatf("%s c%0d gnt", tag, cyc), 32'(bus.gnt), 32'(expGnt));
    checkOutput($sformatf("%s c%0d ack", tag, cyc), 32'(bus.ack), 32'(expAck));
    checkOutput($sformatf("%s c%0d wr_en", tag, cyc), 32'(bus.wr_en), 32'(expWrEn));
    checkOutput($sformatf("%s c%0d wr_addr", tag, cyc), 32'(bus.wr_addr), 32'(expAddr));
    checkOutput($sformatf("%s c%0d wr_data", tag, cyc), 32'(bus.wr_data), 32'(expData));
    checkOutput($sformatf("%s c%0d wptr_gray", tag, cyc), 32'(bus.wptr_gray), 32'(tbGray(expWbin)));
    checkOutput($sformatf("%s c%0d fifo_full", tag, cyc), 32'(bus.fifo_full), 32'(1'b0));
    if (expAck != 4'b0) begin
      o = 0;
      for (int i = 0; i < NREQ; i++) if (expAck[i]) o = i;
      expWrEn = 1'b1;
      expAddr = expWbin[2:0];
      expData = dinv[o*8 +: 8];
      expWbin = expWbin + 4'd1;
    end else begin
      expWrEn = 1'b0;
    end
    cyc++;
    tick();
  endtask

  task automatic burstSeq(input string tag, input logic [3:0] mask, input int owner, input int nAcks);
    cycleStep(tag, mask, 4'b0, 4'b0);
    for (int k = 0; k < nAcks; k++) cycleStep(tag, mask, 4'(1 << owner), 4'(1 << owner));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;

    // Single requester: three words then release.
    doReset();
    vecs.push_back(mk(4'b0001, 8'hA1, 4'h0, 4'b0000, 4'b0000, 0, 3'd0, 8'h00, 4'h0, 0));
    vecs.push_back(mk(4'b0001, 8'hA1, 4'h0, 4'b0001, 4'b0001, 0, 3'd0, 8'h00, 4'h0, 0));
    vecs.push_back(mk(4'b0001, 8'hA2, 4'h0, 4'b0001, 4'b0001, 1, 3'd0, 8'hA1, 4'h1, 0));
    vecs.push_back(mk(4'b0001, 8'hA3, 4'h0, 4'b0001, 4'b0001, 1, 3'd1, 8'hA2, 4'h3, 0));
    vecs.push_back(mk(4'b0000, 8'h00, 4'h0, 4'b0001, 4'b0000, 1, 3'd2, 8'hA3, 4'h2, 0));
    vecs.push_back(mk(4'b0000, 8'h00, 4'h0, 4'b0000, 4'b0000, 0, 3'd2, 8'hA3, 4'h2, 0));
    runVectors("single");

    // Fill to full, recover from IDLE, full mid-burst, release while full.
    doReset();
    vecs.push_back(mk(4'b0100, 8'hC0, 4'h0, 4'b0000, 4'b0000, 0, 3'd0, 8'h00, 4'h0, 0));
    vecs.push_back(mk(4'b0100, 8'hC1, 4'h0, 4'b0100, 4'b0100, 0, 3'd0, 8'h00, 4'h0, 0));
    vecs.push_back(mk(4'b0100, 8'hC2, 4'h0, 4'b0100, 4'b0100, 1, 3'd0, 8'hC1, 4'h1, 0));
    vecs.push_back(mk(4'b0100, 8'hC3, 4'h0, 4'b0100, 4'b0100, 1, 3'd1, 8'hC2, 4'h3, 0));
    vecs.push_back(mk(4'b0100, 8'hC4, 4'h0, 4'b0100, 4'b0100, 1, 3'd2, 8'hC3, 4'h2, 0));
    vecs.push_back(mk(4'b0100, 8'hC5, 4'h0, 4'b0000, 4'b0000, 1, 3'd3, 8'hC4, 4'h6, 0));
    vecs.push_back(mk(4'b0100, 8'hC6, 4'h0, 4'b0100, 4'b0100, 0, 3'd3, 8'hC4, 4'h6, 0));
    vecs.push_back(mk(4'b0100, 8'hC7, 4'h0, 4'b0100, 4'b0100, 1, 3'd4, 8'hC6, 4'h7, 0));
    vecs.push_back(mk(4'b0100, 8'hC8, 4'h0, 4'b0100, 4'b0100, 1, 3'd5, 8'hC7, 4'h5, 0));
    vecs.push_back(mk(4'b0100, 8'hC9, 4'h0, 4'b0100, 4'b0100, 1, 3'd6, 8'hC8, 4'h4, 0));
    vecs.push_back(mk(4'b0100, 8'hCA, 4'h0, 4'b0000, 4'b0000, 1, 3'd7, 8'hC9, 4'hC, 1));
    vecs.push_back(mk(4'b0100, 8'hCB, 4'h0, 4'b0000, 4'b0000, 0, 3'd7, 8'hC9, 4'hC, 1));
    vecs.push_back(mk(4'b0100, 8'hCC, 4'h1, 4'b0000, 4'b0000, 0, 3'd7, 8'hC9, 4'hC, 1));
    vecs.push_back(mk(4'b0100, 8'hCD, 4'h1, 4'b0000, 4'b0000, 0, 3'd7, 8'hC9, 4'hC, 1));
    vecs.push_back(mk(4'b0100, 8'hCE, 4'h1, 4'b0000, 4'b0000, 0, 3'd7, 8'hC9, 4'hC, 0));
    vecs.push_back(mk(4'b0100, 8'hCF, 4'h1, 4'b0100, 4'b0100, 0, 3'd7, 8'hC9, 4'hC, 0));
    vecs.push_back(mk(4'b0100, 8'hD0, 4'h3, 4'b0100, 4'b0000, 1, 3'd0, 8'hCF, 4'hD, 1));
    vecs.push_back(mk(4'b0100, 8'hD1, 4'h3, 4'b0100, 4'b0000, 0, 3'd0, 8'hCF, 4'hD, 1));
    vecs.push_back(mk(4'b0100, 8'hD2, 4'h3, 4'b0100, 4'b0100, 0, 3'd0, 8'hCF, 4'hD, 0));
    vecs.push_back(mk(4'b0011, 8'hD3, 4'h3, 4'b0100, 4'b0000, 1, 3'd1, 8'hD2, 4'hF, 1));
    vecs.push_back(mk(4'b0011, 8'hD4, 4'h3, 4'b0000, 4'b0000, 0, 3'd1, 8'hD2, 4'hF, 1));
    vecs.push_back(mk(4'b0011, 8'hD5, 4'h2, 4'b0000, 4'b0000, 0, 3'd1, 8'hD2, 4'hF, 1));
    vecs.push_back(mk(4'b0011, 8'hD6, 4'h2, 4'b0000, 4'b0000, 0, 3'd1, 8'hD2, 4'hF, 1));
    vecs.push_back(mk(4'b0011, 8'hD7, 4'h2, 4'b0000, 4'b0000, 0, 3'd1, 8'hD2, 4'hF, 0));
    vecs.push_back(mk(4'b0011, 8'hD8, 4'h2, 4'b0001, 4'b0001, 0, 3'd1, 8'hD2, 4'hF, 0));
    vecs.push_back(mk(4'b0000, 8'hD9, 4'h2, 4'b0001, 4'b0000, 1, 3'd2, 8'hD8, 4'hE, 1));
    vecs.push_back(mk(4'b0000, 8'hDA, 4'h2, 4'b0000, 4'b0000, 0, 3'd2, 8'hD8, 4'hE, 1));
    runVectors("full");

    // All requesters active: owners rotate 0,1,2,3,0 with one idle cycle between.
    doReset();
    burstSeq("rr", 4'b1111, 0, 4);
    burstSeq("rr", 4'b1111, 1, 4);
    burstSeq("rr", 4'b1111, 2, 4);
    burstSeq("rr", 4'b1111, 3, 4);
    burstSeq("rr", 4'b1111, 0, 4);
    cycleStep("rr", 4'b0000, 4'b0000, 4'b0000);

    // Twenty writes from one requester take the binary pointer through 15->0.
    doReset();
    for (int b = 0; b < 5; b++) burstSeq("wrap", 4'b0010, 1, 4);
    cycleStep("wrap", 4'b0000, 4'b0000, 4'b0000);

    // Reset between the second and third accept of a burst.
    doReset();
    burstSeq("rst", 4'b0010, 1, 4);
    burstSeq("rst", 4'b0100, 2, 2);
    reset = 1'b1;
    #1;
    checkOutput("rst async gnt", 32'(bus.gnt), 32'(4'b0000));
    checkOutput("rst async ack", 32'(bus.ack), 32'(4'b0000));
    checkOutput("rst async wr_en", 32'(bus.wr_en), 32'(1'b0));
    checkOutput("rst async wr_addr", 32'(bus.wr_addr), 32'(3'd0));
    checkOutput("rst async wr_data", 32'(bus.wr_data), 32'(8'h00));
    checkOutput("rst async wptr_gray", 32'(bus.wptr_gray), 32'(4'h0));
    checkOutput("rst async fifo_full", 32'(bus.fifo_full), 32'(1'b0));
    @(negedge wclk);
    reset = 1'b0;
    #1;
    resetExp();
    cycleStep("postrst", 4'b1111, 4'b0000, 4'b0000);
    cycleStep("postrst", 4'b1111, 4'b0001, 4'b0001);
    cycleStep("postrst", 4'b0000, 4'b0001, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
